// File: rtl/sync_fifo_buffer_if.sv
// Push/pop handshake bundle for sync_fifo_buffer.
// The master modport is the producer/consumer side and the slave modport is the FIFO.
interface sync_fifo_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  write_i;
  logic                  read_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  full_o;
  logic                  empty_o;

  modport master (
    output wr_data_i, write_i, read_i,
    input  rd_data_o, full_o, empty_o
  );

  modport slave (
    input  wr_data_i, write_i, read_i,
    output rd_data_o, full_o, empty_o
  );
endinterface

// File: rtl/sync_fifo_buffer.sv
// Single-clock byte FIFO for the UART TX/RX paths.
// The read port is either first-word fall-through (FWFT=1) or registered on pop (FWFT=0).
module sync_fifo_buffer #(
  parameter int FIFO_DEPTH = 32,
  parameter bit FWFT       = 1'b1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  sync_fifo_buffer_if.slave   bus
);
  // FIFO_DEPTH must be a power of two and at least 2, so AW is at least 1.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  empty, full;
  logic                  wr_accept, rd_accept;
  logic [AW-1:0]         rd_idx;

  // Pointers carry an extra MSB so equal low bits can mean either empty or full.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rd_accept = bus.read_i && !empty;
  assign wr_accept = bus.write_i && (!full || rd_accept);
  assign rd_idx    = rd_ptr_q[AW-1:0];

  assign bus.empty_o = empty;
  assign bus.full_o  = full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data_i;
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rd_data_o = mem_q[rd_idx];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_accept) rd_data_d = mem_q[rd_idx];
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rd_data_q <= '0;
        else          rd_data_q <= rd_data_d;
      end

      assign bus.rd_data_o = rd_data_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Directed bench: a FWFT and a registered-read FIFO (depth 4) driven with identical stimulus.
module tb_sync_fifo_buffer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  sync_fifo_buffer_if #(.DATA_WIDTH(8)) f1 ();
  sync_fifo_buffer_if #(.DATA_WIDTH(8)) f0 ();

  sync_fifo_buffer #(.FIFO_DEPTH(4), .FWFT(1'b1), .DATA_WIDTH(8)) u_fwft (
    .clk_i(clk), .rst_n_i(rst_n), .bus(f1.slave));
  sync_fifo_buffer #(.FIFO_DEPTH(4), .FWFT(1'b0), .DATA_WIDTH(8)) u_reg (
    .clk_i(clk), .rst_n_i(rst_n), .bus(f0.slave));

  always #5 clk = ~clk;

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    f1.write_i = w; f1.wr_data_i = d; f1.read_i = r;
    f0.write_i = w; f0.wr_data_i = d; f0.read_i = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #12;
    checks++; if (f1.empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty_fwft got=%b exp=1", f1.empty_o); end
    checks++; if (f1.full_o !== 1'b0) begin errors++; $display("FAIL rst_full_fwft got=%b exp=0", f1.full_o); end
    checks++; if (f0.empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty_reg got=%b exp=1", f0.empty_o); end
    checks++; if (f0.full_o !== 1'b0) begin errors++; $display("FAIL rst_full_reg got=%b exp=0", f0.full_o); end
    checks++; if (f0.rd_data_o !== 8'h00) begin errors++; $display("FAIL rst_rdata_reg got=%h exp=00", f0.rd_data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 8'hA1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (f1.empty_o !== 1'b0) begin errors++; $display("FAIL single_empty_fwft got=%b exp=0", f1.empty_o); end
    checks++; if (f1.rd_data_o !== 8'hA1) begin errors++; $display("FAIL single_head_fwft got=%h exp=a1", f1.rd_data_o); end
    checks++; if (f0.empty_o !== 1'b0) begin errors++; $display("FAIL single_empty_reg got=%b exp=0", f0.empty_o); end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (f1.empty_o !== 1'b1) begin errors++; $display("FAIL single_pop_empty_fwft got=%b exp=1", f1.empty_o); end
    checks++; if (f0.empty_o !== 1'b1) begin errors++; $display("FAIL single_pop_empty_reg got=%b exp=1", f0.empty_o); end
    checks++; if (f0.rd_data_o !== 8'hA1) begin errors++; $display("FAIL single_pop_data_reg got=%h exp=a1", f0.rd_data_o); end
  endtask

  task automatic fill4(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, base + 8'(i), 1'b0);
      tick();
      checks++;
      if (f1.full_o !== (i == 3)) begin errors++; $display("FAIL fill_full_fwft idx=%0d got=%b exp=%b", i, f1.full_o, (i == 3)); end
      checks++;
      if (f0.full_o !== (i == 3)) begin errors++; $display("FAIL fill_full_reg idx=%0d got=%b exp=%b", i, f0.full_o, (i == 3)); end
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input logic [7:0] first, input int n);
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = first + 8'(i);
      drive(1'b0, 8'h00, 1'b1);
      checks++; if (f1.rd_data_o !== exp) begin errors++; $display("FAIL drain_fwft idx=%0d got=%h exp=%h", i, f1.rd_data_o, exp); end
      tick();
      checks++; if (f0.rd_data_o !== exp) begin errors++; $display("FAIL drain_reg idx=%0d got=%h exp=%h", i, f0.rd_data_o, exp); end
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (f1.empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty_fwft got=%b exp=1", f1.empty_o); end
    checks++; if (f0.empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty_reg got=%b exp=1", f0.empty_o); end
  endtask

  task automatic test_fill_overflow();
    fill4(8'h01);
    drive(1'b1, 8'hFF, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (f1.full_o !== 1'b1) begin errors++; $display("FAIL ovf_full_fwft got=%b exp=1", f1.full_o); end
    checks++; if (f0.full_o !== 1'b1) begin errors++; $display("FAIL ovf_full_reg got=%b exp=1", f0.full_o); end
    drain(8'h01, 4);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      d = 8'h10 + 8'(i);
      drive(1'b1, d, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1);
      checks++; if (f1.rd_data_o !== d) begin errors++; $display("FAIL wrap_fwft idx=%0d got=%h exp=%h", i, f1.rd_data_o, d); end
      tick();
      checks++; if (f0.rd_data_o !== d) begin errors++; $display("FAIL wrap_reg idx=%0d got=%h exp=%h", i, f0.rd_data_o, d); end
      checks++;
      if (f1.empty_o !== 1'b1 || f1.full_o !== 1'b0 || f0.empty_o !== 1'b1 || f0.full_o !== 1'b0) begin
        errors++;
        $display("FAIL wrap_flags idx=%0d got=%b%b%b%b exp=1010", i, f1.empty_o, f1.full_o, f0.empty_o, f0.full_o);
      end
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_full_rw();
    fill4(8'h01);
    drive(1'b1, 8'h05, 1'b1);
    checks++; if (f1.rd_data_o !== 8'h01) begin errors++; $display("FAIL fullrw_head_fwft got=%h exp=01", f1.rd_data_o); end
    tick();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (f1.full_o !== 1'b1) begin errors++; $display("FAIL fullrw_full_fwft got=%b exp=1", f1.full_o); end
    checks++; if (f0.full_o !== 1'b1) begin errors++; $display("FAIL fullrw_full_reg got=%b exp=1", f0.full_o); end
    checks++; if (f0.rd_data_o !== 8'h01) begin errors++; $display("FAIL fullrw_data_reg got=%h exp=01", f0.rd_data_o); end
    drain(8'h02, 4);
  endtask

  task automatic test_empty_read();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    checks++; if (f1.empty_o !== 1'b1) begin errors++; $display("FAIL eread_empty_fwft got=%b exp=1", f1.empty_o); end
    checks++; if (f0.rd_data_o !== 8'h05) begin errors++; $display("FAIL eread_hold_reg got=%h exp=05", f0.rd_data_o); end
    drive(1'b1, 8'h77, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (f1.empty_o !== 1'b0) begin errors++; $display("FAIL erw_empty_fwft got=%b exp=0", f1.empty_o); end
    checks++; if (f0.empty_o !== 1'b0) begin errors++; $display("FAIL erw_empty_reg got=%b exp=0", f0.empty_o); end
    checks++; if (f0.rd_data_o !== 8'h05) begin errors++; $display("FAIL erw_hold_reg got=%h exp=05", f0.rd_data_o); end
    drain(8'h77, 1);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h33, 1'b0);
    tick();
    drive(1'b1, 8'h34, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (f1.empty_o !== 1'b0) begin errors++; $display("FAIL arst_pre_empty got=%b exp=0", f1.empty_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (f1.empty_o !== 1'b1) begin errors++; $display("FAIL arst_empty_fwft got=%b exp=1", f1.empty_o); end
    checks++; if (f0.empty_o !== 1'b1) begin errors++; $display("FAIL arst_empty_reg got=%b exp=1", f0.empty_o); end
    checks++; if (f0.rd_data_o !== 8'h00) begin errors++; $display("FAIL arst_rdata_reg got=%h exp=00", f0.rd_data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (f1.empty_o !== 1'b1 || f1.full_o !== 1'b0) begin errors++; $display("FAIL arst_post_flags got=%b%b exp=10", f1.empty_o, f1.full_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_wrap();
    test_full_rw();
    test_empty_read();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo_buffer.md
Name: sync_fifo_buffer

Overview:
- Synchronous single-clock FIFO used as the UART TX/RX data buffer.
- Writers push bytes while the consumer FSM pops them.
- Supports first-word fall-through (FWFT) mode, in which the head word is visible on the read port before any read strobe, and a standard registered-read mode.
- The UART transmitter instantiates it with DATA_WIDTH 8 and FWFT 1.

Parameters:
- FIFO_DEPTH, 32, number of entries; must be a power of two, at least 2.
- FWFT, 1, 1 = first-word fall-through read port; 0 = standard registered read.
- DATA_WIDTH, 8, word width in bits.

Ports:
- clk_i  input  1  system clock, all state updates on rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- wr_data_i  input  DATA_WIDTH  word to push.
- write_i  input  1  push strobe, one word per cycle while high.
- read_i  input  1  pop strobe, one word per cycle while high.
- rd_data_o  output  DATA_WIDTH  read data.
- full_o  output  1  FIFO holds FIFO_DEPTH words.
- empty_o  output  1  FIFO holds zero words.

Behaviour:
- Storage and pointers:
  - Storage is a FIFO_DEPTH x DATA_WIDTH array.
  - Write and read pointers are each log2(FIFO_DEPTH)+1 bits wide; the extra MSB disambiguates full from empty.
  - Pointers wrap modulo 2*FIFO_DEPTH; the low bits address the array.
- Flags (combinational from pointers):
  - empty_o = (wr_ptr == rd_ptr).
  - full_o = low bits equal AND MSBs differ.
- Reset (rst_n_i low, asynchronous):
  - Pointers are 0, so empty_o=1 and full_o=0.
  - Registered rd_data_o is 0.
  - Array contents are not cleared.
  - A reset mid-operation discards all stored words immediately.
- Write accept:
  - A write is accepted when write_i=1 and (full_o=0 or a read is accepted in the same cycle).
  - On accept: mem[wr_ptr] <= wr_data_i, wr_ptr += 1.
  - A write while full with no accepted read is ignored; no pointer change, no data corruption.
- Read accept:
  - A read is accepted when read_i=1 and empty_o=0. On accept, rd_ptr += 1.
  - A read while empty is ignored, including when a write occurs in the same cycle. The written word becomes visible next cycle.
- Simultaneous accepted read and write:
  - Occupancy is unchanged and flags hold.
  - When full, both proceed; full_o stays 1.
- FWFT=1:
  - rd_data_o = mem[rd_ptr], combinational, valid whenever empty_o=0.
  - The first written word appears on rd_data_o the cycle after the write (when empty_o falls).
  - The consumer samples rd_data_o in the same cycle it asserts read_i. The next word is presented the following cycle.
  - rd_data_o is don't-care while empty.
- FWFT=0:
  - On an accepted read, rd_data_o <= mem[rd_ptr], valid the cycle after read_i.
  - rd_data_o holds its value otherwise, including on ignored reads.
- Latency:
  - A written word is poppable one cycle after the write.
  - full_o and empty_o update one cycle after the accepted operation.
- No overflow/underflow error outputs.

Test Plan:
- Reset then idle: rst_n_i low → empty_o=1, full_o=0. In FWFT=0, rd_data_o=0. Asynchronous assert mid-cycle clears the flags without waiting for a clock edge.
- FWFT=1, depth 4: write 0xA1 → next cycle empty_o=0 and rd_data_o=0xA1. Pulse read_i → empty_o=1.
- Fill depth 4 with 0x01..0x04 → full_o=1 after the 4th write. A 5th write of 0xFF is ignored. Reads return 0x01,0x02,0x03,0x04 in order, and empty_o=1 after the last.
- Wrap-around: 10 write/read pairs through depth 4 with incrementing data → every read matches in order; no spurious full or empty.
- Simultaneous read+write while full (contents 0x01..0x04), writing 0x05 → full_o stays 1; subsequent reads return 0x02,0x03,0x04,0x05.
- Read while empty, and read+write while empty → read ignored, pointers intact. FWFT=0: rd_data_o unchanged. The written word is read correctly on the next read.
